// File: rtl/nrzi_pkg.sv
// rtl/nrzi_pkg.sv - shared lock-state type and default constants for the NRZI clock/data recovery block
package nrzi_pkg;

   typedef enum logic {
      LK_UNLOCKED = 1'b0,
      LK_LOCKED   = 1'b1
   } lk_state_t;

   localparam int NRZI_OSR_DEF        = 8;
   localparam int NRZI_MAX_RUN_DEF    = 10;
   localparam int NRZI_SYNC_ZEROS_DEF = 10;

endpackage

// File: rtl/nrzi_sync.sv
// rtl/nrzi_sync.sv - multi-stage input synchroniser with history flop producing a line-transition flag
module nrzi_sync
   import nrzi_pkg::*;
#(
   parameter int SYNC_STAGES = 3
)(
   input  logic refclk,
   input  logic reset_n,
   input  logic line_in,
   output logic transition
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // shift the raw line through the synchroniser; history holds the previous settled level
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], line_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // synchroniser and history registers
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign transition = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/nrzi_cdr.sv
// rtl/nrzi_cdr.sv - NRZI oversampling CDR with lock tracking; NRZI_CDR_SYNC_DET_EN enables ADAT sync-gap detection
module nrzi_cdr
   import nrzi_pkg::*;
#(
   parameter int OSR         = NRZI_OSR_DEF,
   parameter int SYNC_STAGES = 3,
   parameter int MAX_RUN     = NRZI_MAX_RUN_DEF,
   parameter int SYNC_ZEROS  = NRZI_SYNC_ZEROS_DEF,
   parameter int LOCK_BITS   = 64
)(
   input  logic refclk,
   input  logic reset_n,
   input  logic in,
   output logic bit_valid,
   output logic bit_out,
   output logic symbol_err,
   output logic locked,
   output logic sync_pulse
);

   localparam int CW      = $clog2(OSR);
   localparam int RUN_TOP = (MAX_RUN > SYNC_ZEROS) ? MAX_RUN : SYNC_ZEROS;
   localparam int RW      = $clog2(RUN_TOP + 2);
   localparam int LW      = $clog2(LOCK_BITS + 1);

   localparam logic [CW-1:0] CNT_MID   = CW'(OSR / 2 - 1);
   localparam logic [CW-1:0] CNT_TOP   = CW'(OSR - 1);
   localparam logic [RW-1:0] RUN_MAX   = RW'(MAX_RUN);
   localparam logic [RW-1:0] RUN_SAT   = RW'(MAX_RUN + 1);
   localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_BITS - 1);

   logic          transition;
   logic          strobe, runt, run_bad;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pending_q, pending_d;
   logic          bit_valid_q, bit_valid_d;
   logic          bit_out_q, bit_out_d;
   logic          symbol_err_q, symbol_err_d;
   logic [RW-1:0] run_q, run_d;
   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   lk_state_t     state_q, state_d;

   nrzi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .refclk     (refclk),
      .reset_n    (reset_n),
      .line_in    (in),
      .transition (transition)
   );

   // bit-phase tracking: re-centre on each edge, sample mid-cell, flag a second edge inside one cell
   always_comb begin
      strobe = (cnt_q == CNT_MID) && !transition;
      runt   = transition && pending_q && (cnt_q < CNT_MID);
      if (transition || (cnt_q == CNT_TOP)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
      pending_d = pending_q;
      if (transition) begin
         pending_d = 1'b1;
      end else if (strobe) begin
         pending_d = 1'b0;
      end
      bit_valid_d  = strobe;
      bit_out_d    = strobe && pending_q;
      symbol_err_d = runt;
   end

   // zero-run length of emitted bits; an emitted zero that pushes past MAX_RUN is a loss-of-signal hint
   always_comb begin
      run_d   = run_q;
      run_bad = 1'b0;
      if (strobe) begin
         if (pending_q) begin
            run_d = '0;
         end else begin
            if (run_q < RUN_SAT) begin
               run_d = run_q + RW'(1);
            end
            run_bad = (run_q >= RUN_MAX);
         end
      end
   end

   // lock FSM: count clean bits to lock, drop on any runt edge or over-long zero run
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         LK_UNLOCKED: begin
            if (runt || run_bad) begin
               lock_cnt_d = '0;
            end else if (strobe) begin
               if (lock_cnt_q == LOCK_LAST) begin
                  state_d    = LK_LOCKED;
                  lock_cnt_d = '0;
               end else begin
                  lock_cnt_d = lock_cnt_q + LW'(1);
               end
            end
         end
         LK_LOCKED: begin
            if (runt || run_bad) begin
               state_d = LK_UNLOCKED;
            end
         end
         default: state_d = LK_UNLOCKED;
      endcase
   end

   // state and output registers
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q        <= '0;
         pending_q    <= 1'b0;
         bit_valid_q  <= 1'b0;
         bit_out_q    <= 1'b0;
         symbol_err_q <= 1'b0;
         run_q        <= '0;
         lock_cnt_q   <= '0;
         state_q      <= LK_UNLOCKED;
      end else begin
         cnt_q        <= cnt_d;
         pending_q    <= pending_d;
         bit_valid_q  <= bit_valid_d;
         bit_out_q    <= bit_out_d;
         symbol_err_q <= symbol_err_d;
         run_q        <= run_d;
         lock_cnt_q   <= lock_cnt_d;
         state_q      <= state_d;
      end
   end

   assign bit_valid  = bit_valid_q;
   assign bit_out    = bit_out_q;
   assign symbol_err = symbol_err_q;
   assign locked     = (state_q == LK_LOCKED);

`ifdef NRZI_CDR_SYNC_DET_EN
   localparam logic [RW-1:0] RUN_SYNC = RW'(SYNC_ZEROS);

   logic sync_pulse_q, sync_pulse_d;

   // a 1-bit that closes exactly SYNC_ZEROS zeros while locked marks the ADAT frame gap
   always_comb begin
      sync_pulse_d = strobe && pending_q && (state_q == LK_LOCKED) && (run_q == RUN_SYNC);
   end

   // sync pulse register, aligned with bit_valid
   always_ff @(posedge refclk or negedge reset_n) begin
      if (!reset_n) begin
         sync_pulse_q <= 1'b0;
      end else begin
         sync_pulse_q <= sync_pulse_d;
      end
   end

   assign sync_pulse = sync_pulse_q;
`else
   assign sync_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_nrzi_cdr.sv
// tb/tb_nrzi_cdr.sv - directed self-checking bench for nrzi_cdr at default parameters
module tb_nrzi_cdr;

`ifdef NRZI_CDR_SYNC_DET_EN
   localparam logic [31:0] SYNC_EXP = 32'd1;
`else
   localparam logic [31:0] SYNC_EXP = 32'd0;
`endif

   logic refclk  = 1'b0;
   logic reset_n = 1'b0;
   logic line_in = 1'b0;
   logic bit_valid, bit_out, symbol_err, locked, sync_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   logic log_bit[$];
   logic log_lock[$];
   logic log_sync[$];
   int   err_cnt         = 0;
   int   sync_cnt        = 0;
   logic err_locked      = 1'b0;
   logic err_prev_locked = 1'b0;
   logic prev_locked     = 1'b0;
   int   jit[8]          = '{0, 2, -2, 1, -1, 2, 0, -2};
   int   jp              = 0;

   nrzi_cdr dut (
      .refclk     (refclk),
      .reset_n    (reset_n),
      .in         (line_in),
      .bit_valid  (bit_valid),
      .bit_out    (bit_out),
      .symbol_err (symbol_err),
      .locked     (locked),
      .sync_pulse (sync_pulse)
   );

   always #5 refclk = ~refclk;

   always @(negedge refclk) begin
      if (bit_valid) begin
         log_bit.push_back(bit_out);
         log_lock.push_back(locked);
         log_sync.push_back(sync_pulse);
      end
      if (sync_pulse) sync_cnt++;
      if (symbol_err) begin
         err_cnt++;
         err_locked      = locked;
         err_prev_locked = prev_locked;
      end
      prev_locked = locked;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   task automatic wait_valid(input int max, output int n, output logic bo);
      n  = -1;
      bo = 1'bx;
      for (int i = 1; i <= max; i++) begin
         tick();
         if (bit_valid) begin
            n  = i;
            bo = bit_out;
            break;
         end
      end
   endtask

   task automatic stream(input int periods);
      for (int p = 0; p < periods; p++) begin
         line_in = ~line_in;
         repeat (32 + jit[jp % 8]) tick();
         jp++;
      end
   endtask

   task automatic clear_log();
      log_bit.delete();
      log_lock.delete();
      log_sync.delete();
      err_cnt  = 0;
      sync_cnt = 0;
   endtask

   function automatic int first_one();
      for (int i = 0; i < log_bit.size(); i++) begin
         if (log_bit[i] === 1'b1) return i;
      end
      return -1;
   endfunction

   function automatic int count_ones(input int from, input int len);
      int c = 0;
      for (int i = from; i < from + len; i++) begin
         if (i >= 0 && i < log_bit.size() && log_bit[i] === 1'b1) c++;
      end
      return c;
   endfunction

   initial begin
      int   n;
      logic bo;
      int   f;

      // reset with line idle
      repeat (5) tick();
      chk("reset_outputs", {27'd0, bit_valid, bit_out, symbol_err, locked, sync_pulse}, 0);

      // idle line: first strobe 4 edges after release, then every 8 with zeros
      reset_n = 1'b1;
      wait_valid(20, n, bo);
      chk("first_strobe_delay", n, 4);
      chk("first_strobe_bit", bo, 0);
      wait_valid(20, n, bo);
      chk("idle_spacing", n, 8);
      chk("idle_bit", bo, 0);
      wait_valid(20, n, bo);
      chk("idle_spacing2", n, 8);
      chk("idle_locked", locked, 0);

      // single edge right after a strobe: 1-bit 8 edges later (7 after sampling edge)
      line_in = 1'b1;
      wait_valid(20, n, bo);
      chk("edge_latency", n, 8);
      chk("edge_bit", bo, 1);
      wait_valid(20, n, bo);
      chk("post_edge_spacing", n, 8);
      chk("post_edge_bit", bo, 0);
      chk("idle_symbol_err", err_cnt, 0);
      repeat (120) tick();

      // ADAT-like stream with jitter: lock on the 64th bit counted from the first 1
      clear_log();
      stream(20);
      f = first_one();
      chk("stream_ones", count_ones(f, 64), 16);
      chk("lock_before_64", log_lock[f + 62], 0);
      chk("lock_at_64", log_lock[f + 63], 1);
      chk("stream_symbol_err", err_cnt, 0);

      // runt: two edges two cycles apart while locked
      clear_log();
      line_in = ~line_in;
      tick();
      tick();
      line_in = ~line_in;
      repeat (32) tick();
      chk("runt_err_count", err_cnt, 1);
      chk("runt_locked_with_err", err_locked, 0);
      chk("runt_locked_before", err_prev_locked, 1);
      chk("runt_one_bit", count_ones(0, log_bit.size()), 1);

      clear_log();
      stream(18);
      chk("relock_after_runt", locked, 1);

      // 10-zero gap then 11-zero gap
      clear_log();
      line_in = ~line_in;
      repeat (88) tick();
      line_in = ~line_in;
      repeat (96) tick();
      line_in = ~line_in;
      repeat (40) tick();
      f = first_one();
      chk("sync_gap_zeros", count_ones(f + 1, 10), 0);
      chk("sync_gap_one", log_bit[f + 11], 1);
      chk("sync_pulse_10", log_sync[f + 11], SYNC_EXP);
      chk("sync_locked_10", log_lock[f + 11], 1);
      chk("long_gap_zero10_locked", log_lock[f + 21], 1);
      chk("long_gap_zero11_locked", log_lock[f + 22], 0);
      chk("long_gap_one", log_bit[f + 23], 1);
      chk("long_gap_no_sync", log_sync[f + 23], 0);
      chk("sync_pulse_total", sync_cnt, SYNC_EXP);

      // relock, then asynchronous reset while bit_valid is high
      clear_log();
      stream(17);
      chk("relock_after_gap", locked, 1);
      wait_valid(16, n, bo);
      chk("pre_reset_valid", bit_valid, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_outputs", {27'd0, bit_valid, bit_out, symbol_err, locked, sync_pulse}, 0);
      tick();
      tick();

      // relock from scratch needs 64 clean strobes after release
      clear_log();
      reset_n = 1'b1;
      stream(17);
      chk("post_reset_err", err_cnt, 0);
      chk("post_reset_lock_63", log_lock[62], 0);
      chk("post_reset_lock_64", log_lock[63], 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
